meter_timer: RTL
================

# meter_timer

Parking-meter time keeper that owns the 4-digit BCD remaining-time value. Sits directly upstream of the 4-digit 7-segment display driver and downstream of the per-button single-pulse debouncers. Accepts add-time pulses and preset switches, decrements once per second, and drives the BCD digits plus blink and expiry flags consumed by the display driver.

## Interface
- TICK_DIV, 100000000: fastclk cycles per one-second tick; even, ≥ 4.
- fastclk  input  1  100 MHz system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- add_u  input  1  single-cycle pulse: add 10 s.
- add_l  input  1  single-cycle pulse: add 180 s.
- add_r  input  1  single-cycle pulse: add 200 s.
- add_d  input  1  single-cycle pulse: add 550 s.
- sw0  input  1  level: preset to 0015 while high.
- sw1  input  1  level: preset to 0185 while high.
- bcd  output  16  remaining time; [15:12] thousands … [3:0] units; each nibble 0–9.
- blank  output  1  high = display driver blanks all digits (blink phase off).
- expired  output  1  high when bcd == 0000.
- tick  output  1  one-cycle pulse on each one-second boundary.

## Operation
- One-cycle event priority: sw0 > sw1 > add (add_u > add_l > add_r > add_d; lower-priority simultaneous pulses dropped) > decrement.
- Preset: while sw0 or sw1 is high, bcd is loaded every cycle; adds and ticks ignored; prescaler held at 0; blank = 0.
- Add: BCD digit-wise addition with carry; any carry out of thousands digit saturates bcd to 9999. Adding to 0000 is allowed (meter restarts).
- Decrement: on tick, bcd − 1 with BCD borrow (e.g. 1000 → 0999); at 0000 stays 0000.
- Add and tick in same cycle: add applied; decrement deferred via a pending flag and applied the next cycle with no event; pending flag cleared by preset.
- Prescaler counts 0..TICK_DIV−1, free-running except when preset held; tick asserted when count = TICK_DIV−1; half-point at count = TICK_DIV/2−1.
- Blink state machine, states NORMAL, LOW, EXPIRED, chosen from bcd after update:
  - NORMAL (bcd ≥ 0200): blank = 0.
  - LOW (0001–0199): blank toggles on every tick (2 s period, 50 %); entered with blank = 0.
  - EXPIRED (0000): blank toggles on every tick and every half-point (1 s period); entered with blank = 0.
  - Any state change forces blank = 0 in the same update.

## Timing
- Reset values: bcd = 0000, blank = 0, expired = 1, tick = 0, prescaler = 0, pending = 0, state EXPIRED.
- All outputs registered; bcd/expired reflect an event one cycle after the event cycle.
- tick high in cycle where prescaler = TICK_DIV−1; decremented bcd visible the following cycle.
- Deferred decrement: visible two cycles after the colliding tick.
- First tick after preset release: TICK_DIV cycles after release.
- rst_n asserted mid-operation: all state returns to reset values immediately; pending decrement and blink phase lost.

## Configuration
- METER_TIMER_BLINK_EN defined: blink state machine as above.
- Not defined: blink logic omitted; blank tied to 0; expired and all other behaviour unchanged.

## Test plan
- TICK_DIV = 10; reset, pulse sw0 one cycle then release -> bcd = 0015, decrements to 0014 eleven cycles after release, 0000 after 15 ticks, stays 0000, expired = 1.
- bcd = 9990, pulse add_d -> bcd = 9999 (saturate); bcd = 0995, pulse add_u -> 1005.
- add_u and add_d in same cycle at 0100 -> 0110 only.
- add_l coincident with tick at 0300 -> 0480 next cycle, 0479 one cycle later.
- Blink on at 0150: blank toggles each tick; at 0000 toggles every 5 cycles; add_r from 0000 -> 0200, blank = 0; with macro undefined blank never asserts.
- sw1 held while ticking and pulsing add_u -> bcd stays 0185; rst_n low mid-count -> bcd = 0000, expired = 1 immediately.

Source files
------------

// File: rtl/meter_timer.sv
// meter_timer
//   Parking-meter time keeper. Owns the 4-digit BCD remaining time, adds time
//   on button pulses, loads presets from switches and counts down once per
//   second. Feeds the 7-segment display driver.
//
//   Optional feature macro: METER_TIMER_BLINK_EN
//     defined     -> blink state machine drives 'blank' (NORMAL / LOW / EXPIRED)
//     not defined -> 'blank' is tied low
//
// Parameters:
//   TICK_DIV  fastclk cycles per one-second tick (even, >= 4)
// Ports:
//   fastclk   system clock, all state on rising edge
//   rst_n     asynchronous active-low reset
//   add_u/l/r/d  single-cycle add pulses: 10 / 180 / 200 / 550 seconds
//   sw0, sw1  level presets: 0015 / 0185, loaded every cycle while high
//   bcd       remaining time, [15:12] thousands .. [3:0] units
//   blank     display blanking (blink off-phase)
//   expired   high when bcd == 0000
//   tick      one-cycle pulse on each one-second boundary
module meter_timer #(
   parameter int unsigned TICK_DIV = 100000000
) (
   input  logic        fastclk,
   input  logic        rst_n,
   input  logic        add_u,
   input  logic        add_l,
   input  logic        add_r,
   input  logic        add_d,
   input  logic        sw0,
   input  logic        sw1,
   output logic [15:0] bcd,
   output logic        blank,
   output logic        expired,
   output logic        tick
);

   localparam int unsigned   PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [15:0]   bcd_q, bcd_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          pending_q, pending_d;
   logic          expired_q, expired_d;
   logic          tick_q, tick_d;
   logic          preset;
   logic          add_any;
   logic [15:0]   add_amt;
   logic [16:0]   add_sum;

   // Digit-wise BCD add; bit 16 is the carry out of the thousands digit.
   function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] sum;
      logic [4:0]  s;
      logic        c;
      sum = '0;
      c   = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         s = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0000, c};
         if (s > 5'd9) begin
            s = s - 5'd10;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         sum[i*4 +: 4] = s[3:0];
      end
      return {c, sum};
   endfunction

   // BCD minus one with borrow; 0000 stays 0000.
   function automatic logic [15:0] bcd_dec(input logic [15:0] a);
      logic [15:0] r;
      logic        borrow;
      r      = a;
      borrow = (a != 16'h0000);
      for (int unsigned i = 0; i < 4; i++) begin
         if (borrow) begin
            if (a[i*4 +: 4] == 4'd0) begin
               r[i*4 +: 4] = 4'd9;
            end else begin
               r[i*4 +: 4] = a[i*4 +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      preset  = sw0 | sw1;
      add_any = add_u | add_l | add_r | add_d;
      if (add_u)      add_amt = 16'h0010;
      else if (add_l) add_amt = 16'h0180;
      else if (add_r) add_amt = 16'h0200;
      else            add_amt = 16'h0550;
      add_sum   = bcd_add(bcd_q, add_amt);
      bcd_d     = bcd_q;
      pending_d = pending_q;
      presc_d   = (presc_q == PRE_LAST) ? '0 : presc_q + PW'(1);

      if (sw0) begin
         bcd_d     = 16'h0015;
         pending_d = 1'b0;
         presc_d   = '0;
      end else if (sw1) begin
         bcd_d     = 16'h0185;
         pending_d = 1'b0;
         presc_d   = '0;
      end else if (add_any) begin
         bcd_d = add_sum[16] ? 16'h9999 : add_sum[15:0];
         // A tick colliding with an add is remembered and applied later.
         if (tick_q) pending_d = 1'b1;
      end else if (tick_q) begin
         bcd_d = bcd_dec(bcd_q);
      end else if (pending_q) begin
         bcd_d     = bcd_dec(bcd_q);
         pending_d = 1'b0;
      end

      // Registered tick: high exactly while the prescaler holds its last value.
      tick_d    = (presc_d == PRE_LAST);
      expired_d = (bcd_d == 16'h0000);
   end

   always_ff @(posedge fastclk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_q     <= '0;
         presc_q   <= '0;
         pending_q <= 1'b0;
         expired_q <= 1'b1;
         tick_q    <= 1'b0;
      end else begin
         bcd_q     <= bcd_d;
         presc_q   <= presc_d;
         pending_q <= pending_d;
         expired_q <= expired_d;
         tick_q    <= tick_d;
      end
   end

   assign bcd     = bcd_q;
   assign expired = expired_q;
   assign tick    = tick_q;

`ifdef METER_TIMER_BLINK_EN
   localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2 - 1);

   typedef enum logic [1:0] {
      ST_NORMAL,
      ST_LOW,
      ST_EXPIRED
   } blink_state_e;

   blink_state_e state_q, state_d;
   logic         blank_q, blank_d;
   logic         half;

   always_comb begin
      half = (presc_q == PRE_HALF);
      // State follows the value bcd is about to take.
      if (bcd_d == 16'h0000)     state_d = ST_EXPIRED;
      else if (bcd_d < 16'h0200) state_d = ST_LOW;
      else                       state_d = ST_NORMAL;

      blank_d = blank_q;
      if (preset || (state_d != state_q)) begin
         blank_d = 1'b0;
      end else begin
         case (state_q)
            ST_LOW:     if (tick_q)         blank_d = ~blank_q;
            ST_EXPIRED: if (tick_q || half) blank_d = ~blank_q;
            default:                        blank_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge fastclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EXPIRED;
         blank_q <= 1'b0;
      end else begin
         state_q <= state_d;
         blank_q <= blank_d;
      end
   end

   assign blank = blank_q;
`else
   assign blank = 1'b0;
`endif

endmodule
